// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-multiplier error meter.
package approx_pkg;

    // Collector FSM states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    // Default widths: 2N-bit product, sample/error counters, and a sum
    // wide enough to absorb a full window of worst-case distances.
    localparam int PROD_W = 64;
    localparam int CNT_W  = 16;
    localparam int ACC_W  = PROD_W + CNT_W;

endpackage

// File: rtl/approx_err_meter_abs_diff.sv
// Stage 1: registered unsigned absolute difference with a nonzero flag.
module abs_diff #(
    parameter int W = approx_pkg::PROD_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_in,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         valid_out,
    output logic [W-1:0] ed,
    output logic         nz
);

    logic [W:0]   diff;
    logic [W:0]   mag;

    // Signed W+1-bit difference; its magnitude always fits in W bits.
    always_comb begin
        diff = {1'b0, a} - {1'b0, b};
        mag  = diff[W] ? (~diff + 1'b1) : diff;
    end

    // Capture the distance only when a sample is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            ed        <= '0;
            nz        <= 1'b0;
        end else begin
            valid_out <= valid_in;
            if (valid_in) begin
                ed <= mag[W-1:0];
                nz <= (mag[W-1:0] != '0);
            end
        end
    end

endmodule

// File: rtl/approx_err_meter.sv
// Error-metric collector downstream of the approximate Booth multiplier:
// accumulates error count, saturating distance sum and maximum distance
// over a programmed window of samples.
module approx_err_meter
    import approx_pkg::*;
#(
    parameter int W     = approx_pkg::PROD_W,
    parameter int CNT_W = approx_pkg::CNT_W,
    parameter int ACC_W = approx_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     p_approx,
    input  logic [W-1:0]     p_exact,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_ed,
    output logic [W-1:0]     max_ed,
    output logic [CNT_W-1:0] samples_seen
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] len_q;
    logic             accept;
    logic             start_ok;
    logic             last;
    logic             s1_valid;
    logic [W-1:0]     s1_ed;
    logic             s1_nz;
    logic [ACC_W:0]   sum_wide;

    // in_ready is a registered copy of (state == RUN), so the handshake
    // below is equivalent to accepting only in RUN.
    assign accept   = in_valid & in_ready;
    assign start_ok = (state == IDLE) & start;
    assign last     = (samples_seen == len_q - 1'b1);

    abs_diff #(
        .W (W)
    ) u_stage1 (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (accept),
        .a         (p_approx),
        .b         (p_exact),
        .valid_out (s1_valid),
        .ed        (s1_ed),
        .nz        (s1_nz)
    );

    // Next-state logic for the window sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (num_samples != '0) ? RUN : DONE;
            RUN:     if (accept && last) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register plus status flags registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == RUN);
            busy     <= (state_next == RUN) || (state_next == DRAIN);
            done     <= (state_next == DONE);
        end
    end

    // Saturating sum candidate: one extra bit catches the overflow.
    always_comb begin
        sum_wide = {1'b0, sum_ed} + {{(ACC_W + 1 - W){1'b0}}, s1_ed};
    end

    // Window length, sample counter and stage-2 accumulators.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q        <= '0;
            samples_seen <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else if (start_ok) begin
            len_q        <= num_samples;
            samples_seen <= '0;
            err_count    <= '0;
            sum_ed       <= '0;
            max_ed       <= '0;
        end else begin
            if (accept) begin
                samples_seen <= samples_seen + 1'b1;
            end
            if (s1_valid) begin
                err_count <= err_count + {{(CNT_W - 1){1'b0}}, s1_nz};
                sum_ed    <= sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
                if (s1_ed > max_ed) begin
                    max_ed <= s1_ed;
                end
            end
        end
    end

endmodule

// File: tb/tb_approx_err_meter.sv
// Directed self-checking bench for approx_err_meter.
module tb_approx_err_meter;

    localparam int W     = 64;
    localparam int CNT_W = 16;
    localparam int ACC_W = 80;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     p_approx;
    logic [W-1:0]     p_exact;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] err_count;
    logic [ACC_W-1:0] sum_ed;
    logic [W-1:0]     max_ed;
    logic [CNT_W-1:0] samples_seen;

    int total = 0;
    int bad   = 0;

    approx_err_meter #(
        .W     (W),
        .CNT_W (CNT_W),
        .ACC_W (ACC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_samples  (num_samples),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .p_approx     (p_approx),
        .p_exact      (p_exact),
        .busy         (busy),
        .done         (done),
        .err_count    (err_count),
        .sum_ed       (sum_ed),
        .max_ed       (max_ed),
        .samples_seen (samples_seen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs and samples change 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        p_approx = a;
        p_exact  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic begin_window(input logic [CNT_W-1:0] n);
        start       = 1'b1;
        num_samples = n;
        step();
        start       = 1'b0;
    endtask

    task automatic check_results(input string tag, input logic [CNT_W-1:0] e,
                                 input logic [ACC_W-1:0] s, input logic [W-1:0] m,
                                 input logic [CNT_W-1:0] n);
        check({tag, ".err_count"}, err_count, e);
        check({tag, ".sum_ed"}, sum_ed, s);
        check({tag, ".max_ed"}, max_ed, m);
        check({tag, ".samples_seen"}, samples_seen, n);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
        p_approx = '0; p_exact = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset values
        check("rst.in_ready", in_ready, 0);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        check_results("rst", 0, 0, 0, 0);

        // Reset in the middle of a window
        begin_window(10);
        check("mid.busy", busy, 1);
        check("mid.in_ready", in_ready, 1);
        repeat (4) send(100, 90);
        check("mid.seen_before_rst", samples_seen, 4);
        rst = 1'b1;
        #1;
        check("mid.rst_busy", busy, 0);
        check("mid.rst_in_ready", in_ready, 0);
        check("mid.rst_done", done, 0);
        check_results("mid.rst", 0, 0, 0, 0);
        #2;
        rst = 1'b0;
        step();
        check("mid.idle_busy", busy, 0);

        // Exact window: no errors
        begin_window(4);
        repeat (4) send(64'h1234, 64'h1234);
        check("exact.drain_in_ready", in_ready, 0);
        check("exact.drain_busy", busy, 1);
        check("exact.drain_done", done, 0);
        step();
        check("exact.done", done, 1);
        check("exact.busy_done", busy, 0);
        check_results("exact", 0, 0, 0, 4);
        step();
        check("exact.done_pulse_end", done, 0);

        // Mixed errors, including the largest possible distance
        begin_window(4);
        send(100, 90);
        send(50, 50);
        send(0, 64'hFFFF_FFFF_FFFF_FFFF);
        send(7, 12);
        step();
        check("mixed.done", done, 1);
        check_results("mixed", 3, 80'h1_0000_0000_0000_000E, 64'hFFFF_FFFF_FFFF_FFFF, 4);
        repeat (3) step();
        check("mixed.held_err", err_count, 3);
        check("mixed.held_sum", sum_ed, 80'h1_0000_0000_0000_000E);

        // Handshake gaps, ignored start in RUN, sample dropped in DRAIN
        begin_window(3);
        check("gap.cleared_err", err_count, 0);
        in_valid = 1'b1; p_approx = 10; p_exact = 3;
        start = 1'b1; num_samples = 1;
        step();
        start = 1'b0;
        in_valid = 1'b0; p_approx = 1000; p_exact = 0;
        step();
        step();
        send(4, 9);
        send(20, 20);
        check("gap.drain_in_ready", in_ready, 0);
        check("gap.seen_at_last", samples_seen, 3);
        in_valid = 1'b1; p_approx = 999; p_exact = 0;
        step();
        in_valid = 1'b0;
        check("gap.done", done, 1);
        check_results("gap", 2, 12, 7, 3);
        step();
        check("gap.after_done_seen", samples_seen, 3);
        check("gap.after_done_max", max_ed, 7);

        // Zero-length window
        begin_window(0);
        check("zero.done", done, 1);
        check("zero.in_ready", in_ready, 0);
        check("zero.busy", busy, 0);
        check_results("zero", 0, 0, 0, 0);
        step();
        check("zero.done_end", done, 0);
        check("zero.in_ready_after", in_ready, 0);

        // Back-to-back windows; start during DONE must be ignored
        begin_window(2);
        send(5, 1);
        send(1, 5);
        start = 1'b1; num_samples = 1;
        step();
        check("b2b.first_done", done, 1);
        check_results("b2b.first", 2, 8, 4, 2);
        step();
        check("b2b.done_start_ignored", busy, 0);
        check("b2b.held_err", err_count, 2);
        check("b2b.held_sum", sum_ed, 8);
        step();
        start = 1'b0;
        check("b2b.second_busy", busy, 1);
        check("b2b.second_cleared_sum", sum_ed, 0);
        check("b2b.second_seen", samples_seen, 0);
        send(3, 0);
        step();
        check("b2b.second_done", done, 1);
        check_results("b2b.second", 1, 3, 3, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
